// File: rtl/button_event_arbiter_if.sv
// Event handshake between button_event_arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
  parameter int ID_W = 3
) ();
  logic            event_valid;
  logic            event_ready;
  logic [ID_W-1:0] event_id;

  modport master (output event_valid, output event_id, input event_ready);
  modport slave  (input event_valid, input event_id, output event_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin serialiser of debounced button press pulses onto a valid/ready event stream.
// Optional macro BTN_ARB_DROP_CNT_EN adds a saturating lost-press counter (drop_count).
module button_event_arbiter #(
  parameter int N_BTN  = 5,
  parameter int ID_W   = 3,
  parameter int DROP_W = 8
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [N_BTN-1:0]       pulse_in,
  button_event_arbiter_if.master ev,
  output logic [N_BTN-1:0]       pending_out,
  output logic                   busy
`ifdef BTN_ARB_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]      drop_count
`endif
);

  if (N_BTN < 2 || N_BTN > 16 || (1 << ID_W) < N_BTN || DROP_W < 1 || DROP_W > 32) begin : g_param_check
    $error("button_event_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic             valid_r;
  logic [ID_W-1:0]  id_r;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_BTN-1:0] pending;

  logic             load;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [N_BTN-1:0] win_oh;
  logic [N_BTN-1:0] clr;
  int unsigned      idx;

  // Walk the offsets from farthest to nearest so the nearest set bit after rr_ptr is the last write.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    win_oh = '0;
    idx    = 0;
    for (int unsigned k = N_BTN; k >= 1; k--) begin
      idx = (32'(rr_ptr) + k) % 32'(N_BTN);
      if (pending[idx]) begin
        found       = 1'b1;
        winner      = ID_W'(idx);
        win_oh      = '0;
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign load = (state == IDLE) || (valid_r && ev.event_ready);
  assign clr  = (load && found) ? win_oh : '0;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= IDLE;
      valid_r <= 1'b0;
      id_r    <= '0;
      rr_ptr  <= ID_W'(N_BTN - 1);
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | pulse_in;
      if (load) begin
        if (found) begin
          state   <= OFFER;
          valid_r <= 1'b1;
          id_r    <= winner;
          rr_ptr  <= winner;
        end else begin
          state   <= IDLE;
          valid_r <= 1'b0;
        end
      end
    end
  end

  assign ev.event_valid = valid_r;
  assign ev.event_id    = id_r;
  assign pending_out    = pending;
  assign busy           = valid_r | (|pending);

`ifdef BTN_ARB_DROP_CNT_EN
  localparam longint unsigned DROP_MAX = (64'd1 << DROP_W) - 64'd1;

  logic [N_BTN-1:0]  drops;
  logic [DROP_W-1:0] drop_cnt_r;
  logic [DROP_W-1:0] drop_next;
  longint unsigned   drop_sum;

  // A press is lost only if its latch is already full and is not being emptied this edge.
  assign drops = pulse_in & pending & ~clr;

  always_comb begin
    drop_sum = 64'(drop_cnt_r);
    for (int unsigned i = 0; i < N_BTN; i++) begin
      drop_sum = drop_sum + 64'(drops[i]);
    end
    drop_next = (drop_sum > DROP_MAX) ? '1 : DROP_W'(drop_sum);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      drop_cnt_r <= '0;
    end else begin
      drop_cnt_r <= drop_next;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_button_event_arbiter;
  localparam int N   = 5;
  localparam int IDW = 3;
  localparam int DW  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pulse;
  logic [N-1:0] pending_out;
  logic         busy;
`ifdef BTN_ARB_DROP_CNT_EN
  logic [DW-1:0] drop_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  button_event_arbiter_if #(.ID_W(IDW)) ev ();

  button_event_arbiter #(.N_BTN(N), .ID_W(IDW), .DROP_W(DW)) dut (
    .clk_in     (clk),
    .reset_in   (rst),
    .pulse_in   (pulse),
    .ev         (ev),
    .pending_out(pending_out),
    .busy       (busy)
`ifdef BTN_ARB_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pending presses as a bit array, last granted index, current offer.
  bit m_pend[N];
  bit m_valid;
  int m_id;
  int m_last;
  int m_drops;

  function automatic void model_step(logic [N-1:0] p, logic rdy, logic r);
    bit ld;
    int w;
    bit granted;
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_id = 0; m_last = N - 1; m_drops = 0;
      return;
    end
    ld = !m_valid || rdy;
    w  = -1;
    for (int j = 1; j <= N; j++) begin
      int b;
      b = (m_last + j) % N;
      if (w < 0 && m_pend[b]) w = b;
    end
    for (int i = 0; i < N; i++) begin
      granted = ld && (w == i);
      if (p[i]) begin
        if (m_pend[i] && !granted && m_drops < 255) m_drops++;
        m_pend[i] = 1'b1;
      end else if (granted) begin
        m_pend[i] = 1'b0;
      end
    end
    if (ld) begin
      if (w >= 0) begin m_valid = 1'b1; m_id = w; m_last = w; end
      else m_valid = 1'b0;
    end
  endfunction

  function automatic logic [N-1:0] m_pvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick(input logic [N-1:0] p, input logic rdy, input logic r);
    pulse = p; ev.event_ready = rdy; rst = r;
    model_step(p, rdy, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(5'b11111, 1'b0, 1'b1);
    tick(5'b11111, 1'b1, 1'b1);
    tick(5'b00000, 1'b0, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ev.event_valid); end
    n_cmp++; if (ev.event_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", ev.event_id); end
    n_cmp++; if (pending_out !== 5'b00000) begin n_fail++; $display("FAIL reset_pending got=%b exp=00000", pending_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef BTN_ARB_DROP_CNT_EN
    n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
`endif
  endtask

  task automatic test_single_stall();
    tick(5'b00100, 1'b0, 1'b0);
    n_cmp++; if (pending_out !== 5'b00100) begin n_fail++; $display("FAIL stall_pending got=%b exp=00100", pending_out); end
    n_cmp++; if (ev.event_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early_valid got=%b exp=0", ev.event_valid); end
    tick(5'b00000, 1'b0, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd2) begin
      n_fail++; $display("FAIL stall_offer got=%b/%0d exp=1/2", ev.event_valid, ev.event_id); end
    for (int c = 0; c < 10; c++) begin
      tick(5'b00000, 1'b0, 1'b0);
      n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%b/%0d exp=1/2", c, ev.event_valid, ev.event_id); end
    end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_accept valid/busy got=%b/%b exp=0/0", ev.event_valid, busy); end
  endtask

  task automatic test_burst();
    logic [IDW-1:0] exp_ids[3];
    exp_ids = '{3'd0, 3'd1, 3'd4};
    tick(5'b00000, 1'b0, 1'b1);
    tick(5'b10011, 1'b1, 1'b0);
    n_cmp++; if (pending_out !== 5'b10011 || ev.event_valid !== 1'b0) begin
      n_fail++; $display("FAIL burst_latch pending/valid got=%b/%b exp=10011/0", pending_out, ev.event_valid); end
    for (int k = 0; k < 3; k++) begin
      tick(5'b00000, 1'b1, 1'b0);
      n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== exp_ids[k]) begin
        n_fail++; $display("FAIL burst_ev[%0d] got=%b/%0d exp=1/%0d", k, ev.event_valid, ev.event_id, exp_ids[k]); end
    end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b0) begin n_fail++; $display("FAIL burst_end got=%b exp=0", ev.event_valid); end
  endtask

  task automatic test_round_robin();
    tick(5'b00000, 1'b0, 1'b1);
    tick(5'b00010, 1'b0, 1'b0);
    tick(5'b00000, 1'b0, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd1) begin
      n_fail++; $display("FAIL rr_first got=%b/%0d exp=1/1", ev.event_valid, ev.event_id); end
    tick(5'b01001, 1'b0, 1'b0);
    n_cmp++; if (pending_out !== 5'b01001 || ev.event_id !== 3'd1) begin
      n_fail++; $display("FAIL rr_pending got=%b/%0d exp=01001/1", pending_out, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd3) begin
      n_fail++; $display("FAIL rr_second got=%b/%0d exp=1/3", ev.event_valid, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd0) begin
      n_fail++; $display("FAIL rr_third got=%b/%0d exp=1/0", ev.event_valid, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b0) begin n_fail++; $display("FAIL rr_end got=%b exp=0", ev.event_valid); end
  endtask

  task automatic test_drop();
    tick(5'b00000, 1'b0, 1'b1);
    tick(5'b01000, 1'b0, 1'b0);
    tick(5'b00000, 1'b0, 1'b0);
    tick(5'b01000, 1'b0, 1'b0);
    n_cmp++; if (pending_out !== 5'b01000 || ev.event_id !== 3'd3 || ev.event_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_reoffer_set got=%b/%0d/%b exp=01000/3/1", pending_out, ev.event_id, ev.event_valid); end
`ifdef BTN_ARB_DROP_CNT_EN
    n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL drop_not_lost got=%0d exp=0", drop_count); end
`endif
    tick(5'b00000, 1'b0, 1'b0);
    tick(5'b01000, 1'b0, 1'b0);
    n_cmp++; if (pending_out !== 5'b01000 || ev.event_id !== 3'd3) begin
      n_fail++; $display("FAIL drop_pending got=%b/%0d exp=01000/3", pending_out, ev.event_id); end
`ifdef BTN_ARB_DROP_CNT_EN
    n_cmp++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count1 got=%0d exp=1", drop_count); end
`endif
    tick(5'b01000, 1'b1, 1'b0);
    n_cmp++; if (pending_out !== 5'b01000 || ev.event_valid !== 1'b1 || ev.event_id !== 3'd3) begin
      n_fail++; $display("FAIL drop_load_set got=%b/%b/%0d exp=01000/1/3", pending_out, ev.event_valid, ev.event_id); end
`ifdef BTN_ARB_DROP_CNT_EN
    n_cmp++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count_hold got=%0d exp=1", drop_count); end
`endif
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (pending_out !== 5'b00000 || ev.event_valid !== 1'b1 || ev.event_id !== 3'd3) begin
      n_fail++; $display("FAIL drop_last got=%b/%b/%0d exp=00000/1/3", pending_out, ev.event_valid, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b0) begin n_fail++; $display("FAIL drop_end got=%b exp=0", ev.event_valid); end
  endtask

  task automatic test_reset_mid();
    tick(5'b00000, 1'b0, 1'b1);
    tick(5'b00001, 1'b0, 1'b0);
    tick(5'b00000, 1'b0, 1'b0);
    tick(5'b00110, 1'b0, 1'b0);
    n_cmp++; if (pending_out !== 5'b00110 || ev.event_valid !== 1'b1 || ev.event_id !== 3'd0) begin
      n_fail++; $display("FAIL mid_setup got=%b/%b/%0d exp=00110/1/0", pending_out, ev.event_valid, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b1);
    n_cmp++; if (pending_out !== 5'b00000 || ev.event_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=%b/%b/%b exp=00000/0/0", pending_out, ev.event_valid, busy); end
    tick(5'b10001, 1'b1, 1'b0);
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd0) begin
      n_fail++; $display("FAIL mid_prio0 got=%b/%0d exp=1/0", ev.event_valid, ev.event_id); end
    tick(5'b00000, 1'b1, 1'b0);
    n_cmp++; if (ev.event_valid !== 1'b1 || ev.event_id !== 3'd4) begin
      n_fail++; $display("FAIL mid_prio4 got=%b/%0d exp=1/4", ev.event_valid, ev.event_id); end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    logic         rdy;
    logic         r;
    tick(5'b00000, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      p   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      rdy = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 99) == 0);
      tick(p, rdy, r);
      n_cmp++; if (ev.event_valid !== m_valid || ev.event_id !== IDW'(m_id) || pending_out !== m_pvec()
                   || busy !== (m_valid || (m_pvec() != '0))) begin
        n_fail++;
        $display("FAIL rand[%0d] valid/id/pending/busy got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", c,
                 ev.event_valid, ev.event_id, pending_out, busy, m_valid, m_id, m_pvec(), (m_valid || (m_pvec() != '0)));
      end
`ifdef BTN_ARB_DROP_CNT_EN
      n_cmp++; if (drop_count !== DW'(m_drops)) begin
        n_fail++; $display("FAIL rand_drop[%0d] got=%0d exp=%0d", c, drop_count, m_drops); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; pulse = '0; ev.event_ready = 1'b0;
    model_step('0, 1'b0, 1'b1);
    test_reset();
    test_single_stall();
    test_burst();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
